// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access stage of a five-stage RISC-V pipeline. Performs byte/half/
//   word stores and sign- or zero-extended loads against a word-organised
//   data memory, selects the write-back value and registers it into the
//   MEM/WB boundary. Misaligned or illegal accesses are suppressed and
//   reported through a sticky error flag.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   sum_out_in    PC+4 from EX/MEM
//   result_in     ALU result; byte address for loads/stores
//   imm_in        immediate (LUI path)
//   rd_in         destination register
//   we_in         register-file write enable
//   controlRF_in  write-back select: 00 ALU, 01 load, 10 PC+4, 11 imm
//   Type_dm_in    access type (funct3): 000 B, 001 H, 010 W, 100 BU, 101 HU
//   data2_in      store data (rs2)
//   store_in      store request
//   wb_data_out   registered write-back value
//   rd_out        registered destination register
//   we_out        registered write enable
//   misalign_err  sticky misaligned/illegal-access flag
module mem_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sum_out_in,
  input  logic [31:0] result_in,
  input  logic [31:0] imm_in,
  input  logic [4:0]  rd_in,
  input  logic        we_in,
  input  logic [1:0]  controlRF_in,
  input  logic [2:0]  Type_dm_in,
  input  logic [31:0] data2_in,
  input  logic        store_in,
  output logic [31:0] wb_data_out,
  output logic [4:0]  rd_out,
  output logic        we_out,
  output logic        misalign_err
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [1:0]    off;
  logic [31:0]   rd_word;
  logic          is_load;
  logic          load_legal;
  logic          store_legal;
  logic          access_err;
  logic          store_commit;
  logic [3:0]    lane_we;
  logic [31:0]   wdata;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic [31:0]   load_data;
  logic [31:0]   wb_sel;

  // Addresses beyond the memory wrap because only the low index bits are used.
  assign word_idx = result_in[AW+1:2];
  assign off      = result_in[1:0];
  assign rd_word  = mem[word_idx];
  assign is_load  = (controlRF_in == WB_LOAD);

  // Legality per access type. Unsigned codes are load-only.
  always_comb begin
    load_legal  = 1'b0;
    store_legal = 1'b0;
    case (Type_dm_in)
      3'b000: begin
        load_legal  = 1'b1;
        store_legal = 1'b1;
      end
      3'b001: begin
        load_legal  = ~off[0];
        store_legal = ~off[0];
      end
      3'b010: begin
        load_legal  = (off == 2'b00);
        store_legal = (off == 2'b00);
      end
      3'b100: load_legal = 1'b1;
      3'b101: load_legal = ~off[0];
      default: ;
    endcase
  end

  // Only memory instructions are checked; ALU/PC+4/immediate paths never fault.
  assign access_err   = (store_in & ~store_legal) | (is_load & ~load_legal);
  assign store_commit = store_in & ~access_err & ~rst;

  always_comb begin
    lane_we = 4'b0000;
    wdata   = data2_in;
    case (Type_dm_in)
      3'b000: begin
        lane_we = 4'b0001 << off;
        wdata   = {4{data2_in[7:0]}};
      end
      3'b001: begin
        lane_we = off[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{data2_in[15:0]}};
      end
      3'b010: lane_we = 4'b1111;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (store_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we[i]) begin
          mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data reflects memory before any same-edge store.
  assign load_byte = rd_word[{off, 3'b000} +: 8];
  assign load_half = off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'h0;
    case (Type_dm_in)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'h0, load_byte};
      3'b101:  load_data = {16'h0, load_half};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    wb_sel = result_in;
    case (controlRF_in)
      WB_ALU:  wb_sel = result_in;
      WB_LOAD: wb_sel = load_data;
      WB_PC4:  wb_sel = sum_out_in;
      WB_IMM:  wb_sel = imm_in;
      default: wb_sel = result_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_out  <= 32'h0;
      rd_out       <= 5'd0;
      we_out       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      wb_data_out  <= access_err ? 32'h0 : wb_sel;
      rd_out       <= rd_in;
      we_out       <= we_in & ~access_err;
      misalign_err <= misalign_err | access_err;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Directed-vector bench for mem_stage. Inputs change 1 ns after a rising
//   edge; registered outputs are sampled 1 ns after the following edge.
module tb_mem_stage;

  localparam int DEPTH_WORDS = 1024;
  localparam int AW          = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sum_out_in;
  logic [31:0] result_in;
  logic [31:0] imm_in;
  logic [4:0]  rd_in;
  logic        we_in;
  logic [1:0]  controlRF_in;
  logic [2:0]  Type_dm_in;
  logic [31:0] data2_in;
  logic        store_in;
  logic [31:0] wb_data_out;
  logic [4:0]  rd_out;
  logic        we_out;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .sum_out_in   (sum_out_in),
    .result_in    (result_in),
    .imm_in       (imm_in),
    .rd_in        (rd_in),
    .we_in        (we_in),
    .controlRF_in (controlRF_in),
    .Type_dm_in   (Type_dm_in),
    .data2_in     (data2_in),
    .store_in     (store_in),
    .wb_data_out  (wb_data_out),
    .rd_out       (rd_out),
    .we_out       (we_out),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    store_in     = 1'b0;
    controlRF_in = 2'b00;
    we_in        = 1'b0;
    rd_in        = 5'd0;
    Type_dm_in   = 3'b010;
    result_in    = 32'h0;
    data2_in     = 32'h0;
  endtask

  task automatic do_store(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] d);
    idle();
    store_in   = 1'b1;
    Type_dm_in = typ;
    result_in  = addr;
    data2_in   = d;
    tick();
    store_in   = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] typ, input logic [31:0] addr);
    idle();
    controlRF_in = 2'b01;
    we_in        = 1'b1;
    rd_in        = 5'd9;
    Type_dm_in   = typ;
    result_in    = addr;
    tick();
  endtask

  initial begin
    sum_out_in = 32'h0;
    imm_in     = 32'h0;
    idle();

    // Reset with a concurrent store and live write-enable.
    rst       = 1'b1;
    store_in  = 1'b1;
    result_in = 32'h10;
    data2_in  = 32'hFFFF_FFFF;
    rd_in     = 5'd7;
    we_in     = 1'b1;
    tick();
    tick();
    check_val("rst_wb",  wb_data_out, 32'h0);
    check_val("rst_rd",  {27'h0, rd_out}, 32'h0);
    check_val("rst_we",  {31'h0, we_out}, 32'h0);
    check_val("rst_err", {31'h0, misalign_err}, 32'h0);
    rst = 1'b0;

    // Give word 4 a known value, then reset again over a store to it.
    do_store(3'b010, 32'h10, 32'h0BAD_F00D);
    rst       = 1'b1;
    store_in  = 1'b1;
    result_in = 32'h10;
    data2_in  = 32'hFFFF_FFFF;
    tick();
    tick();
    rst = 1'b0;
    check_val("rst2_wb", wb_data_out, 32'h0);
    do_load(3'b010, 32'h10);
    check_val("rst_mem_kept", wb_data_out, 32'h0BAD_F00D);
    check_val("rst_err2", {31'h0, misalign_err}, 32'h0);

    // Load extension.
    do_store(3'b010, 32'h20, 32'h8001_7F80);
    check_val("sw_wb_alu", wb_data_out, 32'h20);
    do_load(3'b000, 32'h20);
    check_val("lb_20", wb_data_out, 32'hFFFF_FF80);
    check_val("lb_rd", {27'h0, rd_out}, 32'd9);
    check_val("lb_we", {31'h0, we_out}, 32'h1);
    do_load(3'b000, 32'h21);
    check_val("lb_21", wb_data_out, 32'h0000_007F);
    do_load(3'b100, 32'h20);
    check_val("lbu_20", wb_data_out, 32'h0000_0080);
    do_load(3'b001, 32'h22);
    check_val("lh_22", wb_data_out, 32'hFFFF_8001);
    do_load(3'b101, 32'h22);
    check_val("lhu_22", wb_data_out, 32'h0000_8001);
    do_load(3'b100, 32'h23);
    check_val("lbu_23", wb_data_out, 32'h0000_0080);

    // Byte and half-word stores only touch their lanes.
    do_store(3'b010, 32'h20, 32'h1122_3344);
    do_store(3'b000, 32'h21, 32'h0000_00AB);
    do_load(3'b010, 32'h20);
    check_val("sb_lw", wb_data_out, 32'h1122_AB44);
    do_store(3'b001, 32'h22, 32'h0000_BEEF);
    do_load(3'b010, 32'h20);
    check_val("sh_lw", wb_data_out, 32'hBEEF_AB44);

    // Write-back select.
    idle();
    rd_in      = 5'd5;
    we_in      = 1'b1;
    result_in  = 32'h1;
    sum_out_in = 32'h104;
    imm_in     = 32'h1234_5000;
    controlRF_in = 2'b00;
    tick();
    check_val("wb_alu", wb_data_out, 32'h1);
    check_val("wb_rd",  {27'h0, rd_out}, 32'd5);
    check_val("wb_we",  {31'h0, we_out}, 32'h1);
    controlRF_in = 2'b10;
    tick();
    check_val("wb_pc4", wb_data_out, 32'h104);
    controlRF_in = 2'b11;
    tick();
    check_val("wb_imm", wb_data_out, 32'h1234_5000);
    check_val("wb_no_err", {31'h0, misalign_err}, 32'h0);

    // Load and store together: store commits, write-back sees old data.
    do_store(3'b010, 32'h30, 32'hCAFE_BABE);
    idle();
    store_in     = 1'b1;
    controlRF_in = 2'b01;
    Type_dm_in   = 3'b010;
    result_in    = 32'h30;
    data2_in     = 32'h0102_0304;
    tick();
    check_val("ldst_old", wb_data_out, 32'hCAFE_BABE);
    do_load(3'b010, 32'h30);
    check_val("ldst_new", wb_data_out, 32'h0102_0304);

    // Misaligned store.
    idle();
    store_in   = 1'b1;
    we_in      = 1'b1;
    rd_in      = 5'd3;
    Type_dm_in = 3'b010;
    result_in  = 32'h22;
    data2_in   = 32'hFFFF_FFFF;
    tick();
    check_val("mis_sw_wb",  wb_data_out, 32'h0);
    check_val("mis_sw_we",  {31'h0, we_out}, 32'h0);
    check_val("mis_sw_err", {31'h0, misalign_err}, 32'h1);
    do_load(3'b001, 32'h23);
    check_val("mis_lh_wb",  wb_data_out, 32'h0);
    check_val("mis_lh_we",  {31'h0, we_out}, 32'h0);
    do_store(3'b100, 32'h20, 32'h0000_0055);
    do_load(3'b010, 32'h20);
    check_val("mis_mem_kept", wb_data_out, 32'hBEEF_AB44);
    check_val("mis_sticky",   {31'h0, misalign_err}, 32'h1);
    check_val("legal_we",     {31'h0, we_out}, 32'h1);

    // Wrap-around addressing.
    do_store(3'b010, 32'(4 * DEPTH_WORDS + 8), 32'hDEAD_BEEF);
    do_load(3'b010, 32'h8);
    check_val("wrap_lw", wb_data_out, 32'hDEAD_BEEF);
    check_val("wrap_sticky", {31'h0, misalign_err}, 32'h1);

    // Reset clears the flag.
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_clr_err", {31'h0, misalign_err}, 32'h0);
    do_load(3'b000, 32'h8);
    check_val("post_rst_lb", wb_data_out, 32'hFFFF_FFEF);
    check_val("post_rst_err", {31'h0, misalign_err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
